// File: rtl/reg_mux_arb.sv
// reg_mux_arb: CHANNELS-input registered multiplexer with valid/ready handshakes
// on every port. Selection is either a fixed, control-driven index or a
// round-robin search across valid channels. A single output register provides
// one cycle of latency and absorbs backpressure from the consumer.
module reg_mux_arb #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_ch;
    logic [WIDTH-1:0] grant_data;

    // The output register may take a new word when empty or draining this cycle.
    assign load_en = ~valid_q | out_ready;

    // Grant selection: fixed index, or first valid channel at/after ptr (wrapping at CHANNELS).
    always_comb begin
        int idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_ch   = '0;
        grant_data = '0;
        if (!mode) begin
            // Indices at or above CHANNELS never match, so they never grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if ((SEL_W'(i) == sel) && in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_ch   = SEL_W'(i);
                    grant_data = in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            // Walk from the farthest offset back to ptr so the nearest valid channel wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (in_valid[idx]) begin
                    grant_vld  = 1'b1;
                    grant_ch   = SEL_W'(idx);
                    grant_data = in_data[idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Accept only on the granted channel; nothing is accepted while in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst & load_en & grant_vld & (grant_ch == SEL_W'(i));
        end
    end

    // Next-state: load on transfer, empty on load without grant, hold on stall.
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d = grant_data;
                ch_d   = grant_ch;
                if (mode) begin
                    ptr_d = (grant_ch == SEL_W'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
                end
            end
        end
    end

    // State registers; asynchronous reset clears the held word and the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_reg_mux_arb.sv
// Bench for reg_mux_arb: a 4-channel/16-bit instance and a 3-channel/8-bit
// instance share control inputs and are checked every cycle against a
// behavioural model of the selection rules, plus directed value checks.
module tb_reg_mux_arb;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] d3_data;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;

    int nchk = 0;
    int nerr = 0;

    // Model state per instance (0: 4ch/16b, 1: 3ch/8b)
    logic        m_valid[2];
    logic [15:0] m_data[2];
    int          m_ch[2];
    int          m_ptr[2];

    reg_mux_arb #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    reg_mux_arb #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3_data), .in_valid(in_valid[2:0]),
        .in_ready(in_ready3), .mode(mode), .sel(sel), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel chosen by the rules: -1 means no grant.
    function automatic int exp_grant(int n, logic md, int s, logic [3:0] v, int p);
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("out_valid",  32'(out_valid),  32'(m_valid[0]));
        chk("out_ch",     32'(out_ch),     32'(m_ch[0]));
        chk("out_data",   32'(out_data),   32'(m_data[0]));
        chk("out_valid3", 32'(out_valid3), 32'(m_valid[1]));
        chk("out_ch3",    32'(out_ch3),    32'(m_ch[1]));
        chk("out_data3",  32'(out_data3),  32'(m_data[1][7:0]));
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic step();
        int          g[2];
        int          n;
        logic [3:0]  v;
        logic        le;
        logic [3:0]  er;
        #1;
        for (int d = 0; d < 2; d++) begin
            n    = (d == 0) ? 4 : 3;
            v    = (d == 0) ? in_valid : {1'b0, in_valid[2:0]};
            g[d] = exp_grant(n, mode, int'(sel), v, m_ptr[d]);
            le   = !m_valid[d] || out_ready;
            er   = (le && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
            if (d == 0) chk("in_ready", 32'(in_ready), 32'(er));
            else        chk("in_ready3", 32'(in_ready3), 32'(er));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n  = (d == 0) ? 4 : 3;
            le = !m_valid[d] || out_ready;
            if (le) begin
                if (g[d] >= 0) begin
                    m_valid[d] = 1'b1;
                    m_ch[d]    = g[d];
                    m_data[d]  = (d == 0) ? in_data[g[d]*16 +: 16] : {8'h00, d3_data[g[d]*8 +: 8]};
                    if (mode) m_ptr[d] = (g[d] + 1) % n;
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
        end
        check_outputs();
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_in_ready3", 32'(in_ready3), 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_data();
        in_data = {$urandom, $urandom};
        d3_data = 24'($urandom);
    endtask

    initial begin
        int exp4[6];
        int exp3[4];
        int exp_alt[4];
        exp4    = '{0, 1, 2, 3, 0, 1};
        exp3    = '{0, 1, 2, 0};
        exp_alt = '{1, 3, 1, 3};

        rst       = 1'b0;
        in_data   = '0;
        d3_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Fixed select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        rand_data();
        in_data[2*16 +: 16] = 16'hBEEF;
        step();
        chk("fix_data", 32'(out_data), 32'hBEEF);
        chk("fix_ch",   32'(out_ch),   32'd2);
        // Selected channel not valid: no grant even though others are
        in_valid = 4'b1011;
        step();
        chk("fix_nogrant_valid", 32'(out_valid), 32'd0);

        // Backpressure: hold 0x1234 for three stalled cycles
        sel = 2'd1; in_valid = 4'b1111;
        in_data[1*16 +: 16] = 16'h1234;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            in_valid = 4'($urandom);
            sel      = 2'($urandom);
            step();
            chk("stall_data", 32'(out_data), 32'h1234);
        end
        out_ready = 1'b1; sel = 2'd3; in_valid = 4'b1000;
        in_data[3*16 +: 16] = 16'h5678;
        step();
        chk("unstall_data", 32'(out_data), 32'h5678);

        // Mid-run reset with a held word
        do_reset();

        // Round-robin fairness, all valid
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
            chk("rr_all_ch", 32'(out_ch), 32'(exp4[i]));
            if (i < 4) chk("rr3_all_ch", 32'(out_ch3), 32'(exp3[i]));
        end

        // Alternating channels from a cleared pointer
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step();
            chk("rr_alt_ch", 32'(out_ch), 32'(exp_alt[i]));
        end

        // Skip and wrap: ptr=3 with channels 0,1 valid
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0011;
        step();
        chk("rr_wrap0", 32'(out_ch), 32'd0);
        step();
        chk("rr_wrap1", 32'(out_ch), 32'd1);

        // 3-channel instance: fixed sel=3 never grants
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("c3_sel3_valid", 32'(out_valid3), 32'd0);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rand_data();
            in_valid  = 4'($urandom);
            mode      = ($urandom_range(0, 9) < 7);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/reg_mux_arb.md
Name: reg_mux_arb

Overview:
- Parametrised successor to the 16-bit two-input register mux.
- WIDTH-bit, CHANNELS-input registered multiplexer with per-channel valid/ready handshake and a single-entry output register.
- Two selection modes: fixed select (software/control-driven `sel`) and round-robin arbitration across valid channels.
- Sits between multiple producers (e.g. writeback/forwarding sources) and a single consumer; provides one cycle of latency and backpressure.

Parameters:
- WIDTH, 16, data width per channel.
- CHANNELS, 4, number of input channels; legal range 2 to 2^SEL_W.
- SEL_W, 2, width of the select and channel-ID fields; must satisfy 2^SEL_W >= CHANNELS.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced `out_data`.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts `out_data` this cycle.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is 0 while rst is low.
  - Reset mid-transfer discards the held word; no partial state survives.
- load_en = ~out_valid | out_ready. This is a combinational path from out_ready to in_ready, and it is permitted.
- Grant (combinational, evaluated each cycle):
  - Fixed mode:
    - If sel < CHANNELS and in_valid[sel], grant channel sel.
    - If sel >= CHANNELS or in_valid[sel] is 0, there is no grant, even if other channels are valid.
  - Round-robin mode:
    - Grant the first i with in_valid[i], searching ptr, ptr+1, ..., wrapping modulo CHANNELS.
    - No valid channel means no grant.
- Handshakes:
  - in_ready[g] = load_en & grant_valid, where g is the granted channel. All other in_ready bits are 0.
  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
- On a transfer at a clock edge:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
- On load_en with no grant: out_valid <= 0; out_data and out_ch hold their last value.
- On ~load_en (out_valid=1 and out_ready=0): out_data, out_ch and out_valid all hold. Data must be stable while stalled.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Round-robin pointer:
  - Updated only on a transfer in round-robin mode: ptr <= (g == CHANNELS-1) ? 0 : g+1.
  - Unchanged in fixed mode and on stall cycles.
  - A mode switch takes effect on the same cycle's grant; ptr retains its value across mode switches.
- Simultaneous output drain and input load in the same cycle: the new word replaces the old one; no bubble is inserted.
- Non-power-of-two CHANNELS: the pointer wrap and the sel range check use CHANNELS, not 2^SEL_W.
- Widths: pure selection; no arithmetic on data.

Test Plan:
- Reset and idle: assert rst low mid-run with out_valid=1 -> out_valid=0, out_data=0x0000, out_ch=0 immediately (no clock edge needed); all in_ready=0.
- Fixed mode, sel=2, in_valid=4'b1111, ch2=0xBEEF, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_data=0xBEEF, out_ch=2, out_valid=1. Then set sel=2 with in_valid=4'b1011 -> no grant, and out_valid drops the following cycle.
- Backpressure: out_valid=1 holding 0x1234, out_ready=0 for 3 cycles while inputs change -> in_ready=0, and out_data stays 0x1234 throughout. Raising out_ready loads the next granted word in the same edge with no bubble.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0,1. With in_valid=4'b1010 -> out_ch sequence 1,3,1,3.
- Round-robin skip and wrap: ptr=3, in_valid=4'b0011 -> grant 0, then ptr=1, then grant 1.
- Parameter sweep: CHANNELS=3, SEL_W=2, WIDTH=8:
  - Fixed mode, sel=3 -> never granted.
  - Round-robin -> out_ch sequence 0,1,2,0 (wraps at 3).
